// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and types for the pipeline hazard/flush control logic.
// Branch types, IDflush codes, the active-low flush level and the controller state.
package pipe_ctrl_pkg;

    localparam logic [1:0] BR_EQ   = 2'b00;
    localparam logic [1:0] BR_LT   = 2'b01;
    localparam logic [1:0] BR_GT   = 2'b10;
    localparam logic [1:0] BR_NONE = 2'b11;

    localparam logic [1:0] ID_PASS   = 2'b11;
    localparam logic [1:0] ID_BUBBLE = 2'b01;
    localparam logic [1:0] ID_FLUSH  = 2'b00;

    localparam logic NO_FLUSH = 1'b1;
    localparam logic DO_FLUSH = ~NO_FLUSH;

    localparam int MD_CNT_W = 4;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MD_BUSY = 2'b01,
        HALTED  = 2'b10
    } ctrl_state_e;

    // The comparator result is meaningless unless EX holds a real branch.
    function automatic logic is_branch(input logic [1:0] bra);
        return (bra == BR_EQ) || (bra == BR_LT) || (bra == BR_GT);
    endfunction

endpackage

// File: rtl/md_stall_counter.sv
// Down counter that times a multi-cycle MUL/DIV stall.
// Loaded with the remaining stall length; last_o flags the final busy cycle.
module md_stall_counter
    import pipe_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic [MD_CNT_W-1:0] load_val_i,
    input  logic                dec_i,
    output logic                last_o
);

    logic [MD_CNT_W-1:0] cnt_q;
    logic [MD_CNT_W-1:0] cnt_d;

    // Saturates at zero so a stray decrement can never wrap the count.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == MD_CNT_W'(1));

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Hazard and flush controller: turns the ID/EX control word into flush strobes and
// PC / IF-ID write enables for taken branches, load-use, MUL/DIV stalls and HALT.
module hazard_flush_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W  = 4,
    parameter int MD_LAT = 4
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_down,
    input  logic [REG_W-1:0] ex_dst,
    input  logic [1:0]       ex_bra,
    input  logic             ex_br_taken,
    input  logic             ex_muldiv,
    input  logic             ex_halt,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             IFflush,
    output logic [1:0]       IDflush,
    output logic             EXflush,
    output logic             MEMflush,
    output logic             md_busy,
    output logic             halted
);

    if ((MD_LAT < 2) || (MD_LAT > 15)) begin : g_md_lat_check
        $fatal(1, "hazard_flush_ctrl: MD_LAT must lie within 2..15");
    end

    ctrl_state_e state_q;
    ctrl_state_e state_d;
    logic        md_ack_q;
    logic        md_ack_d;
    logic        cnt_load;
    logic        cnt_dec;
    logic        cnt_last;
    logic        branch_taken;
    logic        load_use;

    assign branch_taken = is_branch(ex_bra) && ex_br_taken;
    assign load_use     = ex_down &&
                          ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));

    md_stall_counter u_md_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (MD_CNT_W'(MD_LAT - 1)),
        .dec_i      (cnt_dec),
        .last_o     (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            md_ack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            md_ack_q <= md_ack_d;
        end
    end

    // While rst is high every strobe shows its idle value, whatever state was held.
    always_comb begin
        state_d  = state_q;
        md_ack_d = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        pc_we    = 1'b1;
        ifid_we  = 1'b1;
        IFflush  = NO_FLUSH;
        IDflush  = ID_PASS;
        EXflush  = NO_FLUSH;
        MEMflush = NO_FLUSH;

        if (rst) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (ex_halt) begin
                        pc_we   = 1'b0;
                        ifid_we = 1'b0;
                        IFflush = DO_FLUSH;
                        IDflush = ID_FLUSH;
                        state_d = HALTED;
                    end else if (branch_taken) begin
                        IFflush = DO_FLUSH;
                        IDflush = ID_FLUSH;
                    end else if (ex_muldiv && !md_ack_q) begin
                        pc_we    = 1'b0;
                        ifid_we  = 1'b0;
                        MEMflush = DO_FLUSH;
                        cnt_load = 1'b1;
                        state_d  = MD_BUSY;
                    end else if (load_use) begin
                        pc_we   = 1'b0;
                        ifid_we = 1'b0;
                        IDflush = ID_BUBBLE;
                    end
                end
                MD_BUSY: begin
                    pc_we    = 1'b0;
                    ifid_we  = 1'b0;
                    MEMflush = DO_FLUSH;
                    cnt_dec  = 1'b1;
                    // md_ack lets the held MUL/DIV leave EX without re-entering the stall.
                    if (cnt_last) begin
                        state_d  = RUN;
                        md_ack_d = 1'b1;
                    end
                end
                HALTED: begin
                    pc_we   = 1'b0;
                    ifid_we = 1'b0;
                    IFflush = DO_FLUSH;
                    IDflush = ID_FLUSH;
                    EXflush = DO_FLUSH;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    assign md_busy = !rst && (state_q == MD_BUSY);
    assign halted  = !rst && (state_q == HALTED);

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Self-checking bench for hazard_flush_ctrl: directed scenarios then random traffic,
// every cycle compared against a cycle-count reference model of the controller.
module tb_hazard_flush_ctrl;

    localparam int REG_W  = 4;
    localparam int MD_LAT = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [REG_W-1:0] id_rs, id_rt, ex_dst;
    logic             id_uses_rt, ex_down, ex_br_taken, ex_muldiv, ex_halt;
    logic [1:0]       ex_bra;
    logic             pc_we, ifid_we, IFflush, EXflush, MEMflush, md_busy, halted;
    logic [1:0]       IDflush;

    int errorCount = 0;
    int checkCount = 0;
    int cycleNum   = 0;

    // Reference model: sticky halt flag, remaining MUL/DIV busy cycles, one-shot ack.
    bit mHalted = 1'b0;
    int mMdLeft = 0;
    bit mAck    = 1'b0;

    hazard_flush_ctrl #(.REG_W(REG_W), .MD_LAT(MD_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_down     (ex_down),
        .ex_dst      (ex_dst),
        .ex_bra      (ex_bra),
        .ex_br_taken (ex_br_taken),
        .ex_muldiv   (ex_muldiv),
        .ex_halt     (ex_halt),
        .pc_we       (pc_we),
        .ifid_we     (ifid_we),
        .IFflush     (IFflush),
        .IDflush     (IDflush),
        .EXflush     (EXflush),
        .MEMflush    (MEMflush),
        .md_busy     (md_busy),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", tag, cycleNum,
                     observed, expected);
        end
    endtask

    // Drives one cycle of inputs, compares every output with the model, advances the model.
    task automatic applyStimulus(input logic r, input logic [REG_W-1:0] rs,
                                 input logic [REG_W-1:0] rt, input logic usesRt,
                                 input logic down, input logic [REG_W-1:0] dst,
                                 input logic [1:0] bra, input logic taken,
                                 input logic md, input logic halt);
        logic       eP, eI, eIF, eEX, eMEM, eBusy, eHalt;
        logic [1:0] eID;
        bit         nH, nAck, loadUse, brTaken;
        int         nLeft;

        @(negedge clk);
        rst = r; id_rs = rs; id_rt = rt; id_uses_rt = usesRt; ex_down = down;
        ex_dst = dst; ex_bra = bra; ex_br_taken = taken; ex_muldiv = md; ex_halt = halt;
        #1;

        eP = 1; eI = 1; eIF = 1; eID = 2'b11; eEX = 1; eMEM = 1; eBusy = 0; eHalt = 0;
        nH = mHalted; nLeft = mMdLeft; nAck = 0;
        loadUse = down && (dst == rs || (usesRt && dst == rt));
        brTaken = (bra != 2'b11) && taken;

        if (r) begin
            nH = 0; nLeft = 0;
        end else if (mHalted) begin
            eP = 0; eI = 0; eIF = 0; eID = 2'b00; eEX = 0; eHalt = 1;
        end else if (mMdLeft > 0) begin
            eP = 0; eI = 0; eMEM = 0; eBusy = 1;
            nLeft = mMdLeft - 1;
            if (nLeft == 0) nAck = 1;
        end else if (halt) begin
            eP = 0; eI = 0; eIF = 0; eID = 2'b00; nH = 1;
        end else if (brTaken) begin
            eIF = 0; eID = 2'b00;
        end else if (md && !mAck) begin
            eP = 0; eI = 0; eMEM = 0; nLeft = MD_LAT - 1;
        end else if (loadUse) begin
            eP = 0; eI = 0; eID = 2'b01;
        end

        checkOutput("pc_we",    32'(pc_we),    32'(eP));
        checkOutput("ifid_we",  32'(ifid_we),  32'(eI));
        checkOutput("IFflush",  32'(IFflush),  32'(eIF));
        checkOutput("IDflush",  32'(IDflush),  32'(eID));
        checkOutput("EXflush",  32'(EXflush),  32'(eEX));
        checkOutput("MEMflush", 32'(MEMflush), 32'(eMEM));
        checkOutput("md_busy",  32'(md_busy),  32'(eBusy));
        checkOutput("halted",   32'(halted),   32'(eHalt));

        @(posedge clk);
        mHalted = nH; mMdLeft = nLeft; mAck = nAck;
        cycleNum++;
    endtask

    task automatic idleCycle(input logic r);
        applyStimulus(r, 4'd0, 4'd0, 1'b0, 1'b0, 4'd9, 2'b11, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_down = 1'b0;
        ex_dst = '0; ex_bra = 2'b11; ex_br_taken = 1'b0; ex_muldiv = 1'b0; ex_halt = 1'b0;

        idleCycle(1'b1);
        idleCycle(1'b1);
        idleCycle(1'b0);

        // Load-use on rs, then on rt, then rt match ignored when not read.
        applyStimulus(0, 4'd3, 4'd5, 0, 1, 4'd3, 2'b11, 0, 0, 0);
        idleCycle(1'b0);
        applyStimulus(0, 4'd1, 4'd7, 1, 1, 4'd7, 2'b11, 0, 0, 0);
        applyStimulus(0, 4'd1, 4'd7, 0, 1, 4'd7, 2'b11, 0, 0, 0);

        // Taken branch beats load-use; not-taken branch is a no-op.
        applyStimulus(0, 4'd3, 4'd5, 0, 1, 4'd3, 2'b01, 1, 0, 0);
        applyStimulus(0, 4'd2, 4'd5, 0, 0, 4'd3, 2'b00, 0, 0, 0);
        applyStimulus(0, 4'd2, 4'd5, 0, 0, 4'd3, 2'b11, 1, 0, 0);

        // MUL held high for stall length plus the release cycle.
        for (int i = 0; i < MD_LAT + 1; i++)
            applyStimulus(0, 4'd0, 4'd0, 0, 0, 4'd9, 2'b11, 0, 1, 0);
        idleCycle(1'b0);

        // Reset during the second MUL/DIV cycle.
        applyStimulus(0, 4'd0, 4'd0, 0, 0, 4'd9, 2'b11, 0, 1, 0);
        applyStimulus(1, 4'd0, 4'd0, 0, 0, 4'd9, 2'b11, 0, 1, 0);
        idleCycle(1'b0);

        // HALT, then 20 cycles of busy-looking inputs that must be ignored.
        applyStimulus(0, 4'd0, 4'd0, 0, 0, 4'd9, 2'b11, 0, 0, 1);
        for (int i = 0; i < 20; i++)
            applyStimulus(0, 4'd3, 4'd3, 1, 1, 4'd3, 2'b10, 1, 1, 1);
        idleCycle(1'b1);
        idleCycle(1'b0);

        // Random traffic with small register range so hazards actually occur.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 59) == 0),
                          4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                          1'($urandom), ($urandom_range(0, 2) == 0),
                          4'($urandom_range(0, 3)), 2'($urandom), 1'($urandom),
                          ($urandom_range(0, 5) == 0), ($urandom_range(0, 49) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
